// File: rtl/ccr_unit.sv
// Condition-code register (Z/C/N) for the five-stage pipeline.
// Flags are updated from the ALU and SETC/CLRC, and a taken conditional jump
// clears the flag it consumed.
// Optional feature: define CCR_SHADOW_EN to build a LIFO shadow stack. The stack
// saves the flags on interrupt entry and restores them on RTI.
module ccr_unit #(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       alu_valid_i,
    input  logic [2:0] alu_mask_i,
    input  logic [2:0] alu_flags_i,
    input  logic       setc_i,
    input  logic       clrc_i,
    input  logic       jmp_taken_i,
    input  logic [1:0] jmp_type_i,
    input  logic       int_save_i,
    input  logic       rti_restore_i,
    output logic [2:0] ccr_o,
    output logic [2:0] depth_cnt_o,
    output logic       shadow_full_o,
    output logic       shadow_empty_o,
    output logic       err_ovf_o,
    output logic       err_unf_o
);

    localparam int unsigned FlagZ = 0;
    localparam int unsigned FlagC = 1;
    localparam int unsigned FlagN = 2;

    logic [2:0] ccr_q, ccr_d;
    logic [2:0] flags_upd;

    // Flag update: ALU write, then C override (clrc wins), then jump consume.
    always_comb begin
        flags_upd = ccr_q;
        for (int i = 0; i < 3; i++) begin
            if (alu_valid_i && alu_mask_i[i]) begin
                flags_upd[i] = alu_flags_i[i];
            end
        end
        if (setc_i) flags_upd[FlagC] = 1'b1;
        if (clrc_i) flags_upd[FlagC] = 1'b0;
        if (jmp_taken_i) begin
            case (jmp_type_i)
                2'd0:    flags_upd[FlagZ] = 1'b0;
                2'd1:    flags_upd[FlagN] = 1'b0;
                2'd2:    flags_upd[FlagC] = 1'b0;
                default: ;
            endcase
        end
    end

`ifdef CCR_SHADOW_EN
    // Storage is sized for the largest legal DEPTH; entries at or above DEPTH
    // are never written and so carry no logic.
    logic [2:0] stack_q [4];
    logic [2:0] depth_q, depth_d;
    logic       ovf_q, ovf_d;
    logic       unf_q, unf_d;
    logic       full, empty;
    logic       do_push, do_pop;
    logic [1:0] push_idx, pop_idx;

    // Stack control: a pop beats a same-cycle push, and the push is flagged as overflow.
    always_comb begin
        full     = (depth_q == 3'(DEPTH));
        empty    = (depth_q == 3'd0);
        do_pop   = rti_restore_i && !empty;
        do_push  = int_save_i && !rti_restore_i && !full;
        push_idx = depth_q[1:0];
        pop_idx  = depth_q[1:0] - 2'd1;
        ccr_d    = do_pop ? stack_q[pop_idx] : flags_upd;
        depth_d  = depth_q;
        if (do_pop) begin
            depth_d = depth_q - 3'd1;
        end else if (do_push) begin
            depth_d = depth_q + 3'd1;
        end
        ovf_d = ovf_q | (int_save_i && (full || rti_restore_i));
        unf_d = unf_q | (rti_restore_i && empty);
    end

    // Flag, depth and sticky error registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ccr_q   <= 3'b000;
            depth_q <= 3'd0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            ccr_q   <= ccr_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack contents need no reset; the pre-update flags are saved.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            stack_q[push_idx] <= ccr_q;
        end
    end

    assign depth_cnt_o    = depth_q;
    assign shadow_full_o  = full;
    assign shadow_empty_o = empty;
    assign err_ovf_o      = ovf_q;
    assign err_unf_o      = unf_q;
`else
    localparam int unsigned unused_depth = DEPTH;
    logic unused_shadow;
    assign unused_shadow = int_save_i ^ rti_restore_i;

    // Without the shadow stack, only the flag update path exists.
    always_comb begin
        ccr_d = flags_upd;
    end

    // Flag register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ccr_q <= 3'b000;
        end else begin
            ccr_q <= ccr_d;
        end
    end

    assign depth_cnt_o    = 3'd0;
    assign shadow_full_o  = 1'b0;
    assign shadow_empty_o = 1'b1;
    assign err_ovf_o      = 1'b0;
    assign err_unf_o      = 1'b0;
`endif

    assign ccr_o = ccr_q;

endmodule
